// File: rtl/reg_query_pkg.sv
// Shared types and constants for the register query engine: status codes,
// FSM state encoding and the stored entry header layout.
package reg_query_pkg;

    localparam logic [7:0] REGQ_SUCCESS   = 8'd0;
    localparam logic [7:0] REGQ_NOT_FOUND = 8'd2;
    localparam logic [7:0] REGQ_MORE_DATA = 8'd234;

    // Header fields are sized for the widest supported configuration; narrower
    // instances zero-extend, so unused upper bits fold away as constants.
    localparam int REGQ_KEY_MAX = 64;
    localparam int REGQ_LEN_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_RESP,
        ST_DATA
    } regq_state_t;

    typedef struct packed {
        logic                    valid;
        logic [REGQ_KEY_MAX-1:0] key;
        logic [3:0]              kind;
        logic [REGQ_LEN_MAX-1:0] len;
    } regq_hdr_t;

    // Index of the final data word for a payload of len bytes.
    function automatic int regq_last_beat(input int len, input int bytes);
        return (len > 0) ? (len - 1) / bytes : 0;
    endfunction

endpackage

// File: rtl/reg_query_rr_arb.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer,
// pointer advances to granted+1 whenever a grant is issued (grant == accept).
module reg_query_rr_arb #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx
);

    logic [CH_W-1:0] ptr_reg;

    // Scan from farthest to nearest so the channel closest to the pointer wins.
    always_comb begin : arb_search
        int c;
        c         = 0;
        grant     = '0;
        grant_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            c = (int'(ptr_reg) + k) % NUM_CH;
            if (en && req[c]) begin
                grant     = '0;
                grant[c]  = 1'b1;
                grant_idx = CH_W'(c);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (|grant) begin
            ptr_reg <= (int'(grant_idx) == NUM_CH - 1) ? '0 : CH_W'(int'(grant_idx) + 1);
        end
    end

endmodule

// File: rtl/reg_query_engine.sv
// Key/value store with round-robin multi-channel two-phase query front end.
// Optional statistics counters: define REGQ_STATS_EN.
module reg_query_engine
    import reg_query_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_W       = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_WORDS   = 8,
    localparam int LEN_W      = $clog2(MAX_WORDS * DATA_W / 8 + 1),
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int IDX_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
    localparam int WORD_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    output logic                    cfg_ready,
    input  logic                    cfg_hdr,
    input  logic                    cfg_del,
    input  logic [IDX_W-1:0]        cfg_idx,
    input  logic [WORD_W-1:0]       cfg_word,
    input  logic [KEY_W-1:0]        cfg_key,
    input  logic [3:0]              cfg_type,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic [DATA_W-1:0]       cfg_data,
    input  logic [NUM_CH-1:0]       req_valid,
    output logic [NUM_CH-1:0]       req_ready,
    input  logic [NUM_CH*KEY_W-1:0] req_key,
    input  logic [NUM_CH*LEN_W-1:0] req_cap,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [CH_W-1:0]         rsp_ch,
    output logic [7:0]              rsp_status,
    output logic [3:0]              rsp_type,
    output logic [LEN_W-1:0]        rsp_len,
    output logic                    dat_valid,
    input  logic                    dat_ready,
    output logic                    dat_last,
    output logic [DATA_W-1:0]       dat_data,
    output logic [15:0]             st_hit,
    output logic [15:0]             st_miss,
    output logic [15:0]             st_more
);

    localparam int BYTES     = DATA_W / 8;
    localparam int MAX_BYTES = MAX_WORDS * BYTES;
    localparam int DEPTH     = NUM_ENTRIES * MAX_WORDS;
    localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    regq_state_t state_reg, state_next;
    logic        run_reg;
    logic        idle;
    logic        accept;

    // run_reg keeps every output low while reset is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) run_reg <= 1'b0;
        else     run_reg <= 1'b1;
    end

    assign idle      = (state_reg == ST_IDLE) && run_reg;
    assign cfg_ready = idle;

    // ---------------- request arbitration and latch ----------------
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic [KEY_W-1:0]  key_arr [NUM_CH];
    logic [LEN_W-1:0]  cap_arr [NUM_CH];
    logic [KEY_W-1:0]  key_reg;
    logic [LEN_W-1:0]  cap_reg;
    logic [CH_W-1:0]   ch_reg;

    reg_query_rr_arb #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (idle),
        .req       (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign key_arr[gi] = req_key[gi*KEY_W +: KEY_W];
            assign cap_arr[gi] = req_cap[gi*LEN_W +: LEN_W];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_reg <= '0;
            cap_reg <= '0;
            ch_reg  <= '0;
        end else if (accept) begin
            key_reg <= key_arr[grant_idx];
            cap_reg <= cap_arr[grant_idx];
            ch_reg  <= grant_idx;
        end
    end

    // ---------------- header table ----------------
    regq_hdr_t        hdr [NUM_ENTRIES];
    logic [LEN_W-1:0] cfg_len_sat;
    logic             cfg_fire;

    assign cfg_fire    = idle && cfg_we;
    assign cfg_len_sat = (cfg_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : cfg_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) hdr[i] <= '0;
        end else if (cfg_fire) begin
            if (cfg_del) begin
                hdr[cfg_idx].valid <= 1'b0;
            end else if (cfg_hdr) begin
                hdr[cfg_idx] <= '{valid: 1'b1,
                                  key:   REGQ_KEY_MAX'(cfg_key),
                                  kind:  cfg_type,
                                  len:   REGQ_LEN_MAX'(cfg_len_sat)};
            end
        end
    end

    // ---------------- parallel lookup ----------------
    logic [NUM_ENTRIES-1:0] match;
    logic                   hit_c;
    logic [IDX_W-1:0]       hit_idx_c;

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_match
            assign match[gi] = hdr[gi].valid && (hdr[gi].key == REGQ_KEY_MAX'(key_reg));
        end
    endgenerate

    // Descending scan: the lowest matching index is assigned last and wins.
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
        end
    end

    logic [7:0]        status_c;
    logic [3:0]        type_c;
    logic [LEN_W-1:0]  len_c;
    logic              go_data_c;
    logic [WORD_W-1:0] last_c;

    always_comb begin
        status_c  = REGQ_NOT_FOUND;
        type_c    = '0;
        len_c     = '0;
        go_data_c = 1'b0;
        last_c    = '0;
        if (hit_c) begin
            type_c = hdr[hit_idx_c].kind;
            len_c  = LEN_W'(hdr[hit_idx_c].len);
            if (cap_reg == '0) begin
                status_c = REGQ_SUCCESS;
            end else if (REGQ_LEN_MAX'(cap_reg) < hdr[hit_idx_c].len) begin
                status_c = REGQ_MORE_DATA;
            end else begin
                status_c  = REGQ_SUCCESS;
                go_data_c = (hdr[hit_idx_c].len != '0);
                last_c    = WORD_W'(regq_last_beat(int'(hdr[hit_idx_c].len), BYTES));
            end
        end
    end

    logic [7:0]        status_reg;
    logic [3:0]        type_reg;
    logic [LEN_W-1:0]  len_reg;
    logic              go_data_reg;
    logic [WORD_W-1:0] last_reg;
    logic [IDX_W-1:0]  hit_idx_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_reg  <= '0;
            type_reg    <= '0;
            len_reg     <= '0;
            go_data_reg <= 1'b0;
            last_reg    <= '0;
            hit_idx_reg <= '0;
        end else if (state_reg == ST_LOOKUP) begin
            status_reg  <= status_c;
            type_reg    <= type_c;
            len_reg     <= len_c;
            go_data_reg <= go_data_c;
            last_reg    <= last_c;
            hit_idx_reg <= hit_idx_c;
        end
    end

    // ---------------- data stream ----------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_reg;
    logic [WORD_W-1:0] beat_reg;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic              dat_fire;
    logic              last_beat;
    int                rd_word;

    assign dat_fire  = dat_valid && dat_ready;
    assign last_beat = (state_reg == ST_DATA) && (beat_reg == last_reg);
    assign wr_addr   = ADDR_W'(int'(cfg_idx) * MAX_WORDS + int'(cfg_word));

    // Prefetch word 0 while the response is pending, then the next word on
    // each accepted beat, so the registered read sustains one beat per cycle.
    always_comb begin
        rd_word = (state_reg == ST_RESP) ? 0 : int'(beat_reg) + 1;
        rd_addr = ADDR_W'(int'(hit_idx_reg) * MAX_WORDS + rd_word);
        rd_en   = (state_reg == ST_RESP) || (dat_fire && !last_beat);
    end

    always_ff @(posedge clk) begin
        if (cfg_fire && !cfg_del && !cfg_hdr) mem[wr_addr] <= cfg_data;
        if (rd_en) rd_data_reg <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         beat_reg <= '0;
        else if (state_reg == ST_RESP)   beat_reg <= '0;
        else if (dat_fire && !last_beat) beat_reg <= beat_reg + 1'b1;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (accept) state_next = ST_LOOKUP;
            ST_LOOKUP: state_next = ST_RESP;
            ST_RESP:   if (rsp_ready) state_next = go_data_reg ? ST_DATA : ST_IDLE;
            ST_DATA:   if (dat_ready && last_beat) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign rsp_valid  = (state_reg == ST_RESP);
    assign rsp_ch     = ch_reg;
    assign rsp_status = status_reg;
    assign rsp_type   = type_reg;
    assign rsp_len    = len_reg;
    assign dat_valid  = (state_reg == ST_DATA);
    assign dat_last   = last_beat;
    assign dat_data   = dat_valid ? rd_data_reg : '0;

    // ---------------- statistics ----------------
`ifdef REGQ_STATS_EN
    logic [15:0] hit_cnt_reg, miss_cnt_reg, more_cnt_reg;
    logic        rsp_fire;

    assign rsp_fire = rsp_valid && rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
            more_cnt_reg <= '0;
        end else if (rsp_fire) begin
            if (status_reg == REGQ_SUCCESS && hit_cnt_reg != 16'hFFFF)
                hit_cnt_reg <= hit_cnt_reg + 16'd1;
            if (status_reg == REGQ_NOT_FOUND && miss_cnt_reg != 16'hFFFF)
                miss_cnt_reg <= miss_cnt_reg + 16'd1;
            if (status_reg == REGQ_MORE_DATA && more_cnt_reg != 16'hFFFF)
                more_cnt_reg <= more_cnt_reg + 16'd1;
        end
    end

    assign st_hit  = hit_cnt_reg;
    assign st_miss = miss_cnt_reg;
    assign st_more = more_cnt_reg;
`else
    assign st_hit  = '0;
    assign st_miss = '0;
    assign st_more = '0;
`endif

endmodule

// File: tb/tb_reg_query_engine.sv
// Self-checking bench for reg_query_engine against a behavioural key/value
// model; expected statistics follow REGQ_STATS_EN when it is defined.
module tb_reg_query_engine;

    localparam int NUM_CH = 2;
    localparam int KEY_W  = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 6;
    localparam int NE     = 16;
    localparam int MW     = 8;

    logic                    clk;
    logic                    rst;
    logic                    cfg_we, cfg_ready, cfg_hdr, cfg_del;
    logic [3:0]              cfg_idx;
    logic [2:0]              cfg_word;
    logic [KEY_W-1:0]        cfg_key;
    logic [3:0]              cfg_type;
    logic [LEN_W-1:0]        cfg_len;
    logic [DATA_W-1:0]       cfg_data;
    logic [NUM_CH-1:0]       req_valid, req_ready;
    logic [NUM_CH*KEY_W-1:0] req_key;
    logic [NUM_CH*LEN_W-1:0] req_cap;
    logic                    rsp_valid, rsp_ready;
    logic [0:0]              rsp_ch;
    logic [7:0]              rsp_status;
    logic [3:0]              rsp_type;
    logic [LEN_W-1:0]        rsp_len;
    logic                    dat_valid, dat_ready, dat_last;
    logic [DATA_W-1:0]       dat_data;
    logic [15:0]             st_hit, st_miss, st_more;

    reg_query_engine dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_hdr(cfg_hdr), .cfg_del(cfg_del),
        .cfg_idx(cfg_idx), .cfg_word(cfg_word), .cfg_key(cfg_key), .cfg_type(cfg_type),
        .cfg_len(cfg_len), .cfg_data(cfg_data),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_cap(req_cap),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ch(rsp_ch), .rsp_status(rsp_status),
        .rsp_type(rsp_type), .rsp_len(rsp_len),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_last(dat_last), .dat_data(dat_data),
        .st_hit(st_hit), .st_miss(st_miss), .st_more(st_more)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the table and bookkeeping
    bit          mvalid [NE];
    logic [31:0] mkey   [NE];
    logic [3:0]  mtype  [NE];
    int          mlen   [NE];
    logic [31:0] mdata  [NE][MW];
    int          rr_ptr;
    int          n_hit, n_miss, n_more;
    int          errors, checks;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_hdr_write(input int idx, input logic [31:0] key, input logic [3:0] t, input int len);
        cfg_we = 1; cfg_hdr = 1; cfg_del = 0;
        cfg_idx = 4'(idx); cfg_key = key; cfg_type = t; cfg_len = 6'(len);
        tick();
        cfg_we = 0; cfg_hdr = 0;
        mvalid[idx] = 1; mkey[idx] = key; mtype[idx] = t;
        mlen[idx] = (len > 32) ? 32 : len;
    endtask

    task automatic cfg_data_write(input int idx, input int w, input logic [31:0] d);
        cfg_we = 1; cfg_hdr = 0; cfg_del = 0;
        cfg_idx = 4'(idx); cfg_word = 3'(w); cfg_data = d;
        tick();
        cfg_we = 0;
        mdata[idx][w] = d;
    endtask

    task automatic cfg_delete(input int idx);
        cfg_we = 1; cfg_del = 1; cfg_idx = 4'(idx);
        tick();
        cfg_we = 0; cfg_del = 0;
        mvalid[idx] = 0;
    endtask

    function automatic void model_query(input logic [31:0] key, input int cap,
                                        output int st, output int typ, output int len,
                                        output int words, output int hidx);
        hidx = -1;
        for (int i = 0; i < NE; i++)
            if (hidx < 0 && mvalid[i] && mkey[i] == key) hidx = i;
        st = 2; typ = 0; len = 0; words = 0;
        if (hidx >= 0) begin
            typ = mtype[hidx];
            len = mlen[hidx];
            if (cap == 0)        st = 0;
            else if (cap < len)  st = 234;
            else begin
                st = 0;
                words = (len + 3) / 4;
            end
        end
    endfunction

    task automatic count_status(input int st);
        if (st == 0)        n_hit++;
        else if (st == 2)   n_miss++;
        else                n_more++;
    endtask

    // Full single-channel query with optional stall and config poke in DATA.
    task automatic run_query(input int ch, input logic [31:0] key, input int cap,
                             input int stall_at, input int stall_len, input bit poke,
                             input string name);
        int st, typ, len, words, h, waited;
        model_query(key, cap, st, typ, len, words, h);
        req_key[ch*KEY_W +: KEY_W] = key;
        req_cap[ch*LEN_W +: LEN_W] = 6'(cap);
        req_valid[ch] = 1'b1;
        waited = 0;
        #1;
        while (!req_ready[ch] && waited < 20) begin
            @(posedge clk); #2; waited++;
        end
        checks++;
        if (!req_ready[ch]) begin
            errors++;
            $display("FAIL %s grant: req_ready=%b after %0d cycles, required ch%0d", name, req_ready, waited, ch);
            req_valid[ch] = 1'b0;
            tick();
            return;
        end
        tick();
        req_valid[ch] = 1'b0;
        rr_ptr = (ch + 1) % NUM_CH;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s latency: rsp_valid=%b at T+1, required 0", name, rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== 8'(st) || rsp_type !== 4'(typ) ||
            rsp_len !== 6'(len) || rsp_ch !== 1'(ch)) begin
            errors++;
            $display("FAIL %s rsp: valid=%b status=%0d type=%0d len=%0d ch=%0d, required 1 %0d %0d %0d %0d",
                     name, rsp_valid, rsp_status, rsp_type, rsp_len, rsp_ch, st, typ, len, ch);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        count_status(st);
        for (int b = 0; b < words; b++) begin
            if (b == stall_at) begin
                dat_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    if (poke) begin
                        cfg_we = 1; cfg_hdr = 1; cfg_del = 0; cfg_idx = 4'd5;
                        cfg_key = 32'h0BAD_0005; cfg_type = 4'd1; cfg_len = 6'd4;
                        #1;
                        checks++;
                        if (cfg_ready !== 1'b0) begin
                            errors++;
                            $display("FAIL %s cfg_ready in DATA: got %b, required 0", name, cfg_ready);
                        end
                    end
                    checks++;
                    if (dat_valid !== 1'b1 || dat_data !== mdata[h][b]) begin
                        errors++;
                        $display("FAIL %s stall beat %0d: valid=%b data=%h, required 1 %h",
                                 name, b, dat_valid, dat_data, mdata[h][b]);
                    end
                    tick();
                end
                cfg_we = 0; cfg_hdr = 0;
            end
            dat_ready = 1'b1;
            checks++;
            if (dat_valid !== 1'b1 || dat_data !== mdata[h][b] || dat_last !== (b == words - 1)) begin
                errors++;
                $display("FAIL %s beat %0d: valid=%b data=%h last=%b, required 1 %h %b",
                         name, b, dat_valid, dat_data, dat_last, mdata[h][b], (b == words - 1));
            end
            tick();
        end
        dat_ready = 1'b0;
        checks++;
        if (dat_valid !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s end: dat_valid=%b cfg_ready=%b, required 0 1", name, dat_valid, cfg_ready);
        end
    endtask

    task automatic check_stats(input string name);
        int eh, em, eo;
`ifdef REGQ_STATS_EN
        eh = n_hit; em = n_miss; eo = n_more;
`else
        eh = 0; em = 0; eo = 0;
`endif
        checks++;
        if (st_hit !== 16'(eh) || st_miss !== 16'(em) || st_more !== 16'(eo)) begin
            errors++;
            $display("FAIL %s: hit=%0d miss=%0d more=%0d, required %0d %0d %0d",
                     name, st_hit, st_miss, st_more, eh, em, eo);
        end else
            $display("stats %s: hit=%0d miss=%0d more=%0d", name, st_hit, st_miss, st_more);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NE; i++) mvalid[i] = 0;
        rr_ptr = 0; n_hit = 0; n_miss = 0; n_more = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (cfg_ready !== 0 || rsp_valid !== 0 || dat_valid !== 0 || dat_last !== 0 ||
            dat_data !== 0 || req_ready !== 0 || rsp_status !== 0 || rsp_len !== 0) begin
            errors++;
            $display("FAIL reset outputs: cfg_ready=%b rsp_valid=%b dat_valid=%b req_ready=%b status=%0d",
                     cfg_ready, rsp_valid, dat_valid, req_ready, rsp_status);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset release: cfg_ready=%b, required 1", cfg_ready);
        end
        check_stats("after_reset");
    endtask

    task automatic test_basic();
        cfg_hdr_write(3, 32'hA5A5_0001, 4'd4, 8);
        cfg_data_write(3, 0, 32'h11);
        cfg_data_write(3, 1, 32'h22);
        run_query(0, 32'hA5A5_0001, 0, -1, 0, 0, "probe");
        run_query(0, 32'hA5A5_0001, 8, 0, 3, 0, "read_stall");
        run_query(0, 32'hA5A5_0001, 4, -1, 0, 0, "more_data");
        run_query(0, 32'h0000_DEAD, 8, -1, 0, 0, "miss");
        check_stats("plan_counts");
    endtask

    task automatic test_round_robin();
        int st, typ, len, words, h, waited, expch;
        req_key = {2{32'hA5A5_0001}};
        req_cap = '0;
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            expch = rr_ptr;
            waited = 0;
            #1;
            while (req_ready == 2'b00 && waited < 20) begin
                @(posedge clk); #2; waited++;
            end
            checks++;
            if (req_ready !== 2'(1 << expch)) begin
                errors++;
                $display("FAIL rr grant %0d: req_ready=%b, required %b", n, req_ready, 2'(1 << expch));
            end
            tick();
            rr_ptr = (expch + 1) % NUM_CH;
            tick();
            model_query(32'hA5A5_0001, 0, st, typ, len, words, h);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_ch !== 1'(expch) || rsp_status !== 8'(st)) begin
                errors++;
                $display("FAIL rr rsp %0d: valid=%b ch=%0d status=%0d, required 1 %0d %0d",
                         n, rsp_valid, rsp_ch, rsp_status, expch, st);
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            count_status(st);
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_delete_and_cfg_block();
        cfg_delete(3);
        run_query(1, 32'hA5A5_0001, 8, -1, 0, 0, "deleted");
        cfg_hdr_write(7, 32'h7777_0007, 4'd9, 12);
        for (int w = 0; w < 3; w++) cfg_data_write(7, w, 32'h7000_0000 + w);
        run_query(1, 32'h7777_0007, 12, 1, 2, 1, "cfg_in_data");
        run_query(0, 32'h0BAD_0005, 0, -1, 0, 0, "poke_ignored");
        run_query(0, 32'h7777_0007, 63, -1, 0, 0, "sat_cap");
    endtask

    task automatic test_random();
        logic [31:0] k;
        for (int e = 8; e < NE; e++) begin
            k = (e == 12) ? mkey[9] : $urandom;
            cfg_hdr_write(e, k, 4'($urandom_range(0, 15)), $urandom_range(0, 40));
            for (int w = 0; w < MW; w++) cfg_data_write(e, w, $urandom);
        end
        for (int q = 0; q < 24; q++) begin
            k = ($urandom_range(0, 4) == 0) ? $urandom : mkey[$urandom_range(7, 15)];
            run_query($urandom_range(0, 1), k, $urandom_range(0, 40),
                      $urandom_range(0, 8), $urandom_range(1, 3), 0, "random");
        end
        check_stats("random_counts");
    endtask

    task automatic test_reset_midstream();
        int waited;
        req_key[0 +: KEY_W] = 32'h7777_0007;
        req_cap[0 +: LEN_W] = 6'd63;
        req_valid[0] = 1'b1;
        waited = 0;
        #1;
        while (!req_ready[0] && waited < 20) begin
            @(posedge clk); #2; waited++;
        end
        tick();
        req_valid[0] = 1'b0;
        tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (dat_valid !== 1'b1) begin
            errors++;
            $display("FAIL midstream setup: dat_valid=%b, required 1", dat_valid);
        end
        rst = 1'b1;
        req_valid[0] = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 0 || dat_valid !== 0 || dat_last !== 0 || dat_data !== 0 ||
            req_ready !== 0 || cfg_ready !== 0 || st_hit !== 0 || st_miss !== 0 || st_more !== 0) begin
            errors++;
            $display("FAIL midstream reset: rsp_valid=%b dat_valid=%b dat_last=%b data=%h req_ready=%b cfg_ready=%b",
                     rsp_valid, dat_valid, dat_last, dat_data, req_ready, cfg_ready);
        end
        req_valid[0] = 1'b0;
        clear_model();
        tick();
        rst = 1'b0;
        tick();
        run_query(0, 32'h7777_0007, 12, -1, 0, 0, "table_cleared");
        check_stats("after_midstream_reset");
    endtask

    initial begin
        errors = 0; checks = 0;
        clear_model();
        rst = 1'b1;
        cfg_we = 0; cfg_hdr = 0; cfg_del = 0; cfg_idx = '0; cfg_word = '0;
        cfg_key = '0; cfg_type = '0; cfg_len = '0; cfg_data = '0;
        req_valid = '0; req_key = '0; req_cap = '0;
        rsp_ready = 0; dat_ready = 0;
        test_reset();
        test_basic();
        test_round_robin();
        test_delete_and_cfg_block();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
